conv_layer_sequencer: RTL and testbench
=======================================

Name: conv_layer_sequencer

Overview:
- Controls one convolution_layer instance through a full layer pass; sits between the AXI-side weight and pixel streams and the layer datapath.
- Per input feature-map set: loads the set's weight words, streams one image of pixels, then waits a fixed drain interval for the pipeline to empty.
- Drives layer_nr and final_set for the whole pass, counts the layer's valid outputs, and pulses done at the end.

Parameters:
- IMG_DIM, 32, input image side; pixels per set = IMG_DIM*IMG_DIM.
- WEIGHT_WORDS, 28, weight words per set (25 kernel taps, bias, bias2, scale).
- DRAIN_CYCLES, 16, idle cycles after the last pixel of a set before the next phase.
- SET_WIDTH, 8, width of the set counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a pass when in IDLE, ignored otherwise.
- cfg_layer_nr  in  32  layer index, captured on accepted start.
- cfg_num_sets  in  SET_WIDTH  input sets for this pass; 0 is treated as 1; captured on start.
- s_wdata  in  32  weight stream data.
- s_wvalid  in  1  weight stream valid.
- s_wready  out  1  weight stream ready.
- s_pdata  in  32  pixel stream data.
- s_pvalid  in  1  pixel stream valid.
- s_pready  out  1  pixel stream ready.
- layer_pixel_valid  in  1  pixel_valid from the layer, used for output counting.
- layer_nr  out  32  to layer; registered copy of cfg_layer_nr.
- final_set  out  1  to layer; high for the whole last set, including its drain.
- weight_we  out  1  to layer; one-cycle write strobe.
- weight_data  out  32  to layer.
- conv_en  out  1  to layer; one-cycle pixel strobe.
- pixel_in  out  32  to layer.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse at end of pass.
- out_count  out  32  layer_pixel_valid pulses since the last accepted start.

Behaviour:
- Reset: every output 0; state IDLE; all counters 0. Asserting reset mid-pass aborts the pass immediately, with no done pulse.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE: start latches the config, clears set_idx and out_count, and sets busy. Next state LOAD_W. final_set is 1 if the effective set count is 1.
- LOAD_W:
  - s_wready=1.
  - A handshake (s_wvalid & s_wready) registers s_wdata to weight_data, and weight_we=1 on the next cycle (1-cycle latency).
  - After WEIGHT_WORDS handshakes, go to STREAM. s_wready drops in the cycle after the last handshake.
- STREAM:
  - s_pready=1.
  - A handshake registers s_pdata to pixel_in, and conv_en=1 on the next cycle.
  - Gaps in s_pvalid give conv_en=0; pixel_in holds its value.
  - After IMG_DIM*IMG_DIM handshakes, go to DRAIN.
- DRAIN:
  - Count DRAIN_CYCLES cycles with both readies at 0.
  - At the end: if set_idx == sets-1, go to DONE. Otherwise increment set_idx and return to LOAD_W.
  - final_set updates on that same transition, set to (new set_idx == sets-1).
- DONE: done=1 for one cycle, busy drops on the same edge, go to IDLE. layer_nr and out_count hold until the next start.
- Outside LOAD_W, s_wready=0; outside STREAM, s_pready=0. Data on the non-active stream is never consumed.
- out_count increments on every cycle where busy=1 and layer_pixel_valid=1, including DRAIN. Pulses in IDLE are ignored. Wraps modulo 2^32.
- The word and pixel counters compare against the parameter minus 1 on the handshake cycle. No extra bubble is inserted between phases.

Test Plan:
- IMG_DIM=4, WEIGHT_WORDS=3, DRAIN_CYCLES=4, cfg_num_sets=1, streams always valid -> exactly 3 weight_we pulses, then 16 consecutive conv_en pulses, final_set=1 throughout, done 4 cycles after the drain begins, busy low after done.
- cfg_num_sets=3, layer_nr=1 -> three LOAD_W/STREAM/DRAIN rounds; final_set rises only at the start of the third LOAD_W; 9 weight_we and 48 conv_en pulses in total.
- s_pvalid toggled every other cycle -> conv_en follows each handshake with 1-cycle latency; still 16 pulses; pixel_in equals the accepted data, in order.
- cfg_num_sets=0 -> behaves as 1 set; start asserted while busy is ignored and config is unchanged.
- Reset asserted mid-STREAM after 7 pixels -> outputs 0 asynchronously, state IDLE, no done; a new start then runs a clean full pass.
- Inject 5 layer_pixel_valid pulses during the pass and 2 while IDLE -> out_count=5 after done.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
// ---------------------
// Runs one convolution layer through a complete pass. For each input
// feature-map set it does three things in order:
//   1. Loads the set's weight words from the weight stream.
//   2. Streams one image of pixels from the pixel stream.
//   3. Waits a fixed drain interval so the layer pipeline can empty.
// The block also drives layer_nr and final_set to the layer for the whole
// pass, counts the layer's valid outputs, and pulses done at the end.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   start                one-cycle pulse; accepted only when idle
//   cfg_layer_nr         layer index, captured on an accepted start
//   cfg_num_sets         number of input sets, captured on start (0 counts as 1)
//   s_w*                 weight stream (valid/ready), consumed only while loading
//   s_p*                 pixel stream (valid/ready), consumed only while streaming
//   layer_pixel_valid    layer output strobe, counted while busy
//   layer_nr, final_set  static controls to the layer
//   weight_we/data       registered weight write, 1 cycle after the handshake
//   conv_en/pixel_in     registered pixel strobe, 1 cycle after the handshake
//   busy, done           pass status; done is a single-cycle pulse
//   out_count            layer outputs seen since the last accepted start
module conv_layer_sequencer #(
  parameter int IMG_DIM      = 32,
  parameter int WEIGHT_WORDS = 28,
  parameter int DRAIN_CYCLES = 16,
  parameter int SET_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          cfg_layer_nr,
  input  logic [SET_WIDTH-1:0] cfg_num_sets,
  input  logic [31:0]          s_wdata,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  input  logic [31:0]          s_pdata,
  input  logic                 s_pvalid,
  output logic                 s_pready,
  input  logic                 layer_pixel_valid,
  output logic [31:0]          layer_nr,
  output logic                 final_set,
  output logic                 weight_we,
  output logic [31:0]          weight_data,
  output logic                 conv_en,
  output logic [31:0]          pixel_in,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          out_count
);

  localparam int PIX_PER_SET = IMG_DIM * IMG_DIM;
  localparam int WCW = $clog2(WEIGHT_WORDS + 1);
  localparam int PCW = $clog2(PIX_PER_SET + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [WCW-1:0] W_LAST = WCW'(WEIGHT_WORDS - 1);
  localparam logic [PCW-1:0] P_LAST = PCW'(PIX_PER_SET - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          layer_nr_q, layer_nr_d;
  logic [SET_WIDTH-1:0] num_sets_q, num_sets_d;
  logic [SET_WIDTH-1:0] set_idx_q, set_idx_d;
  logic [WCW-1:0]       word_cnt_q, word_cnt_d;
  logic [PCW-1:0]       pix_cnt_q, pix_cnt_d;
  logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
  logic                 final_set_q, final_set_d;
  logic                 weight_we_q, weight_we_d;
  logic [31:0]          weight_data_q, weight_data_d;
  logic                 conv_en_q, conv_en_d;
  logic [31:0]          pixel_in_q, pixel_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          out_count_q, out_count_d;

  logic [SET_WIDTH-1:0] eff_sets;
  logic [SET_WIDTH-1:0] next_set_idx;
  logic                 w_hs;
  logic                 p_hs;

  // A zero set count would otherwise underflow the last-set compare.
  assign eff_sets     = (cfg_num_sets == '0) ? SET_WIDTH'(1) : cfg_num_sets;
  assign next_set_idx = set_idx_q + SET_WIDTH'(1);

  // The readies depend only on the state, so the stream that is not
  // active is never consumed.
  assign s_wready = (state_q == S_LOAD_W);
  assign s_pready = (state_q == S_STREAM);
  assign w_hs     = s_wvalid & s_wready;
  assign p_hs     = s_pvalid & s_pready;

  always_comb begin
    state_d       = state_q;
    layer_nr_d    = layer_nr_q;
    num_sets_d    = num_sets_q;
    set_idx_d     = set_idx_q;
    word_cnt_d    = word_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    final_set_d   = final_set_q;
    weight_we_d   = 1'b0;
    weight_data_d = weight_data_q;
    conv_en_d     = 1'b0;
    pixel_in_d    = pixel_in_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    out_count_d   = out_count_q;

    // Outputs are counted in every busy cycle, drain and done included.
    if (busy_q && layer_pixel_valid) begin
      out_count_d = out_count_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          layer_nr_d  = cfg_layer_nr;
          num_sets_d  = eff_sets;
          set_idx_d   = '0;
          word_cnt_d  = '0;
          out_count_d = '0;
          busy_d      = 1'b1;
          final_set_d = (eff_sets == SET_WIDTH'(1));
          state_d     = S_LOAD_W;
        end
      end

      S_LOAD_W: begin
        if (w_hs) begin
          weight_data_d = s_wdata;
          weight_we_d   = 1'b1;
          if (word_cnt_q == W_LAST) begin
            word_cnt_d = '0;
            pix_cnt_d  = '0;
            state_d    = S_STREAM;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end

      S_STREAM: begin
        if (p_hs) begin
          pixel_in_d = s_pdata;
          conv_en_d  = 1'b1;
          if (pix_cnt_q == P_LAST) begin
            pix_cnt_d   = '0;
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + PCW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (drain_cnt_q == D_LAST) begin
          drain_cnt_d = '0;
          if (set_idx_q == num_sets_q - SET_WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            set_idx_d   = next_set_idx;
            word_cnt_d  = '0;
            final_set_d = (next_set_idx == num_sets_q - SET_WIDTH'(1));
            state_d     = S_LOAD_W;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end

      S_DONE: begin
        // done_q is high for this one cycle. busy falls on the same edge
        // that ends the done pulse.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      layer_nr_q    <= '0;
      num_sets_q    <= '0;
      set_idx_q     <= '0;
      word_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      final_set_q   <= 1'b0;
      weight_we_q   <= 1'b0;
      weight_data_q <= '0;
      conv_en_q     <= 1'b0;
      pixel_in_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      out_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      layer_nr_q    <= layer_nr_d;
      num_sets_q    <= num_sets_d;
      set_idx_q     <= set_idx_d;
      word_cnt_q    <= word_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      final_set_q   <= final_set_d;
      weight_we_q   <= weight_we_d;
      weight_data_q <= weight_data_d;
      conv_en_q     <= conv_en_d;
      pixel_in_q    <= pixel_in_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      out_count_q   <= out_count_d;
    end
  end

  assign layer_nr    = layer_nr_q;
  assign final_set   = final_set_q;
  assign weight_we   = weight_we_q;
  assign weight_data = weight_data_q;
  assign conv_en     = conv_en_q;
  assign pixel_in    = pixel_in_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_count   = out_count_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Testbench for conv_layer_sequencer with a small geometry
// (4x4 image, 3 weight words per set, 4 drain cycles).
// Every accepted stream word is pushed into a scoreboard queue on its
// handshake. The matching weight_we / conv_en strobe pops the queue and
// compares the data.
module tb_conv_layer_sequencer;

  localparam int IMG   = 4;
  localparam int WW    = 3;
  localparam int DRAIN = 4;
  localparam int PIX   = IMG * IMG;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] cfg_layer_nr;
  logic [7:0]  cfg_num_sets;
  logic [31:0] s_wdata;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_pdata;
  logic        s_pvalid;
  logic        s_pready;
  logic        layer_pixel_valid;
  logic [31:0] layer_nr;
  logic        final_set;
  logic        weight_we;
  logic [31:0] weight_data;
  logic        conv_en;
  logic [31:0] pixel_in;
  logic        busy;
  logic        done;
  logic [31:0] out_count;

  conv_layer_sequencer #(
    .IMG_DIM(IMG), .WEIGHT_WORDS(WW), .DRAIN_CYCLES(DRAIN), .SET_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_layer_nr(cfg_layer_nr), .cfg_num_sets(cfg_num_sets),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_pdata(s_pdata), .s_pvalid(s_pvalid), .s_pready(s_pready),
    .layer_pixel_valid(layer_pixel_valid),
    .layer_nr(layer_nr), .final_set(final_set),
    .weight_we(weight_we), .weight_data(weight_data),
    .conv_en(conv_en), .pixel_in(pixel_in),
    .busy(busy), .done(done), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and pass bookkeeping.
  logic [31:0] exp_w[$];
  logic [31:0] exp_p[$];
  int  cyc = 0;
  int  w_cnt, p_cnt, done_cnt, wr_hi, eff;
  int  last_conv_cyc, set_first_cyc;
  bit  done_seen;
  bit  prev_w_hs, prev_p_hs;
  bit  p_toggle;

  // Both streams always offer data. The pixel valid optionally toggles
  // every cycle.
  always @(posedge clk) begin
    #1;
    s_wdata  = $urandom;
    s_pdata  = $urandom;
    s_wvalid = 1'b1;
    s_pvalid = p_toggle ? ~s_pvalid : 1'b1;
  end

  // The monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      exp_w.delete();
      exp_p.delete();
      prev_w_hs = 1'b0;
      prev_p_hs = 1'b0;
    end else begin
      if (weight_we || prev_w_hs) check_val("we_latency", 32'(weight_we), 32'(prev_w_hs));
      if (weight_we) begin
        if (exp_w.size() == 0) check_val("w_queue_empty", 32'(exp_w.size()), 32'd1);
        else check_val("weight_data", weight_data, exp_w.pop_front());
        check_val("final_set_w", 32'(final_set), 32'((w_cnt / WW) == eff - 1));
        $display("weight #%0d data=0x%08h final_set=%0b", w_cnt, weight_data, final_set);
        w_cnt++;
      end
      if (conv_en || prev_p_hs) check_val("conv_latency", 32'(conv_en), 32'(prev_p_hs));
      if (conv_en) begin
        if (exp_p.size() == 0) check_val("p_queue_empty", 32'(exp_p.size()), 32'd1);
        else check_val("pixel_in", pixel_in, exp_p.pop_front());
        check_val("final_set_p", 32'(final_set), 32'((p_cnt / PIX) == eff - 1));
        if (p_cnt % PIX == 0) set_first_cyc = cyc;
        if (p_cnt % PIX == PIX - 1)
          check_val("stream_span", 32'(cyc - set_first_cyc), p_toggle ? 32'(2 * (PIX - 1)) : 32'(PIX - 1));
        $display("pixel #%0d data=0x%08h final_set=%0b", p_cnt, pixel_in, final_set);
        last_conv_cyc = cyc;
        p_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_seen = 1'b1;
        check_val("done_latency", 32'(cyc - last_conv_cyc), 32'(DRAIN));
        check_val("busy_at_done", 32'(busy), 32'd1);
        $display("done out_count=%0d", out_count);
      end
      if (s_wready) wr_hi++;
      prev_w_hs = s_wvalid && s_wready;
      prev_p_hs = s_pvalid && s_pready;
      if (prev_w_hs) exp_w.push_back(s_wdata);
      if (prev_p_hs) exp_p.push_back(s_pdata);
    end
  end

  task automatic clear_stats(input int sets_eff);
    w_cnt = 0; p_cnt = 0; done_cnt = 0; wr_hi = 0;
    done_seen = 1'b0; eff = sets_eff; last_conv_cyc = 0;
  endtask

  task automatic run_pass(input logic [31:0] lnr, input logic [7:0] ns,
                          input bit tog, input bit inject, input bit poke);
    clear_stats((ns == 0) ? 1 : int'(ns));
    p_toggle = tog;
    @(posedge clk); #1;
    cfg_layer_nr = lnr;
    cfg_num_sets = ns;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("layer_nr_start", layer_nr, lnr);
    check_val("final_set_start", 32'(final_set), 32'(eff == 1));
    check_val("out_count_cleared", out_count, 32'd0);
    for (int n = 0; n < 2000 && !done_seen; n++) begin
      layer_pixel_valid = inject && (n % 3 == 1) && (n < 15);
      if (poke && n == 5) begin
        start = 1'b1; cfg_layer_nr = ~lnr; cfg_num_sets = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    layer_pixel_valid = 1'b0;
    start = 1'b0;
    if (!done_seen) check_val("pass_timeout", 32'(done_seen), 32'd1);
    repeat (2) @(negedge clk);
    check_val("busy_after_done", 32'(busy), 32'd0);
    check_val("done_count", 32'(done_cnt), 32'd1);
    check_val("weight_we_total", 32'(w_cnt), 32'(WW * eff));
    check_val("conv_en_total", 32'(p_cnt), 32'(PIX * eff));
    check_val("wready_cycles", 32'(wr_hi), 32'(WW * eff));
    check_val("layer_nr_hold", layer_nr, lnr);
    check_val("out_count", out_count, inject ? 32'd5 : 32'd0);
    check_val("w_queue_left", 32'(exp_w.size()), 32'd0);
    check_val("p_queue_left", 32'(exp_p.size()), 32'd0);
    $display("pass layer=%0d sets=%0d weights=%0d pixels=%0d out_count=%0d",
             lnr, eff, w_cnt, p_cnt, out_count);
    if (inject) begin
      // Pulses while idle must be ignored.
      @(posedge clk); #1 layer_pixel_valid = 1'b1;
      @(posedge clk); #1 layer_pixel_valid = 1'b1;
      @(posedge clk); #1 layer_pixel_valid = 1'b0;
      @(negedge clk);
      check_val("out_count_idle_hold", out_count, 32'd5);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_layer_nr = '0; cfg_num_sets = '0;
    layer_pixel_valid = 1'b0; p_toggle = 1'b0;
    s_wdata = '0; s_pdata = '0; s_wvalid = 1'b0; s_pvalid = 1'b0;
    clear_stats(1);
    #3 reset = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_wready", 32'(s_wready), 32'd0);
    check_val("rst_pready", 32'(s_pready), 32'd0);
    check_val("rst_layer_nr", layer_nr, 32'd0);
    check_val("rst_out_count", out_count, 32'd0);
    check_val("rst_final_set", 32'(final_set), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);

    run_pass(32'd1, 8'd1, 1'b0, 1'b0, 1'b0);   // basic single set
    run_pass(32'd1, 8'd3, 1'b0, 1'b0, 1'b0);   // three sets
    run_pass(32'd7, 8'd1, 1'b1, 1'b0, 1'b0);   // pixel valid toggling
    run_pass(32'd9, 8'd0, 1'b0, 1'b0, 1'b1);   // zero sets, start while busy

    // Abort with reset in the middle of streaming.
    clear_stats(1);
    p_toggle = 1'b0;
    @(posedge clk); #1;
    cfg_layer_nr = 32'hABCD; cfg_num_sets = 8'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 200 && p_cnt < 7; n++) begin
      @(negedge clk); #1;
    end
    check_val("abort_pixels", 32'(p_cnt), 32'd7);
    #2 reset = 1'b0;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_pready", 32'(s_pready), 32'd0);
    check_val("abort_conv_en", 32'(conv_en), 32'd0);
    check_val("abort_layer_nr", layer_nr, 32'd0);
    check_val("abort_final_set", 32'(final_set), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("abort_no_done", 32'(done_cnt), 32'd0);
    check_val("abort_stays_idle", 32'(busy), 32'd0);
    $display("abort after %0d pixels busy=%0b", p_cnt, busy);

    run_pass(32'd5, 8'd2, 1'b0, 1'b1, 1'b0);   // clean pass with output counting

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
